mem_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and runs load/store accesses to data memory over a req/ack handshake that tolerates variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers its results toward write-back: ALU result, load data, destination register and WB control bits.

---
 rtl/mem_access_stage_if.sv | 13 +
 rtl/mem_access_stage.sv | 130 +++++++++++++
 tb/tb_mem_access_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Requests are held until ack, which allows memory of any latency.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input  rdata, ack);
  modport slave  (input  req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: runs variable-latency load/store accesses over a req/ack bus,
// stalls upstream while an access is outstanding, and registers results toward WB.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                startin,
  input  logic [31:0]         alu_result_input,
  input  logic [31:0]         read_data_2_input,
  input  logic [4:0]          write_register_input,
  input  logic [1:0]          WB_input,
  input  logic [1:0]          MEM_input,
  mem_access_stage_if.master  dmem,
  output logic                stall,
  output logic [31:0]         alu_result_output,
  output logic [31:0]         read_data_output,
  output logic [4:0]          write_register_output,
  output logic [1:0]          WB_output,
  output logic                misaligned,
  output logic                mem_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   alu_q, alu_d, rd_q, rd_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [1:0]    wb_q, wb_d;
  logic          mis_q, mis_d, tmo_q, tmo_d;

  logic access_req, addr_misal, timeout_hit;

  assign access_req  = MEM_input[1] ^ MEM_input[0];
  assign addr_misal  = |alu_result_input[1:0];
  assign timeout_hit = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !dmem.ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    wreg_d  = wreg_q;
    wb_d    = 2'b00;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        alu_d  = alu_result_input;
        wreg_d = write_register_input;
        rd_d   = 32'd0;
        if (MEM_input == 2'b00) begin
          wb_d = WB_input;
        end else if (access_req && addr_misal) begin
          mis_d = 1'b1;
        end else if (access_req) begin
          // Upstream stays frozen, so the WB fields are picked up again at completion.
          stall   = 1'b1;
          addr_d  = alu_result_input;
          wdata_d = read_data_2_input;
          we_d    = MEM_input[0];
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall = !dmem.ack && !timeout_hit;
        if (dmem.ack) begin
          alu_d   = alu_result_input;
          wreg_d  = write_register_input;
          wb_d    = WB_input;
          rd_d    = we_q ? 32'd0 : dmem.rdata;
          state_d = IDLE;
        end else if (timeout_hit) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (startin) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      alu_q   <= '0;
      rd_q    <= '0;
      wreg_q  <= '0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wreg_q  <= wreg_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dmem.req              = (state_q == ACCESS);
  assign dmem.we               = we_q;
  assign dmem.addr             = addr_q;
  assign dmem.wdata            = wdata_q;
  assign alu_result_output     = alu_q;
  assign read_data_output      = rd_q;
  assign write_register_output = wreg_q;
  assign WB_output             = wb_q;
  assign misaligned            = mis_q;
  assign mem_timeout           = tmo_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random transactions checked
// against a per-instruction outcome model (latency, writeback, pulses).
module tb_mem_access_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        startin;
  logic [31:0] alu_in, wd_in;
  logic [4:0]  wreg_in;
  logic [1:0]  wb_in, mem_in;
  logic        stall, misaligned, mem_timeout;
  logic [31:0] alu_out, rd_out;
  logic [4:0]  wreg_out;
  logic [1:0]  wb_out;

  int n_chk = 0;
  int n_err = 0;

  mem_access_stage_if dif ();

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clk), .startin(startin),
    .alu_result_input(alu_in), .read_data_2_input(wd_in),
    .write_register_input(wreg_in), .WB_input(wb_in), .MEM_input(mem_in),
    .dmem(dif.master), .stall(stall),
    .alu_result_output(alu_out), .read_data_output(rd_out),
    .write_register_output(wreg_out), .WB_output(wb_out),
    .misaligned(misaligned), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},  dif.req, 0);
    chk({tag, "_we"},   dif.we, 0);
    chk({tag, "_addr"}, dif.addr, 0);
    chk({tag, "_wd"},   dif.wdata, 0);
    chk({tag, "_alu"},  alu_out, 0);
    chk({tag, "_rd"},   rd_out, 0);
    chk({tag, "_wreg"}, wreg_out, 0);
    chk({tag, "_wb"},   wb_out, 0);
    chk({tag, "_mis"},  misaligned, 0);
    chk({tag, "_tmo"},  mem_timeout, 0);
  endtask

  // lat = ACCESS cycle (1-based) in which memory acks; 0 or >T means never.
  task automatic run_op(input logic [1:0] mem, input logic [1:0] wb, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] wreg, input int lat,
                        input logic [31:0] rdat);
    bit acc, mis, hit, done, ok;
    int k, exp_k;
    logic [1:0] exp_wb;
    acc = (mem == 2'b01) || (mem == 2'b10);
    mis = acc && (alu[1:0] != 2'b00);
    hit = (lat >= 1) && (lat <= T);
    @(negedge clk);
    mem_in = mem; wb_in = wb; alu_in = alu; wd_in = wd; wreg_in = wreg;
    dif.ack = 1'($urandom_range(0, 1));  // ack in IDLE must be ignored
    dif.rdata = $urandom;
    #1;
    chk("stall_idle", stall, acc && !mis);
    chk("req_idle", dif.req, 0);
    @(posedge clk);
    k = 0;
    if (acc && !mis) begin
      done = 0;
      while (!done) begin
        k++;
        @(negedge clk);
        chk("req_hold", dif.req, 1);
        chk("we", dif.we, mem[0]);
        chk("addr", dif.addr, alu);
        chk("wdata", dif.wdata, wd);
        chk("wb_wait", wb_out, 0);
        dif.ack = (k == lat);
        dif.rdata = rdat;
        #1;
        chk("stall_acc", stall, (k != lat) && (k != T));
        @(posedge clk);
        if (k == lat || k >= T) done = 1;
      end
      exp_k = hit ? lat : T;
      chk("req_cycles", k, exp_k);
    end
    @(negedge clk);
    ok = (mem == 2'b00) || (acc && !mis && hit);
    exp_wb = ok ? wb : 2'b00;
    chk("wb_out", wb_out, exp_wb);
    if (ok) begin
      chk("alu_out", alu_out, alu);
      chk("wreg_out", wreg_out, wreg);
      chk("rd_out", rd_out, (mem == 2'b10) ? rdat : 32'd0);
    end
    chk("misaligned", misaligned, mis);
    chk("mem_timeout", mem_timeout, acc && !mis && !hit);
    chk("req_done", dif.req, 0);
    dif.ack = 1'b0;
    mem_in = 2'b00; wb_in = 2'b00;
  endtask

  initial begin
    startin = 1'b1;
    mem_in = 0; wb_in = 0; alu_in = 0; wd_in = 0; wreg_in = 0;
    dif.ack = 0; dif.rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 chk("reset_stall", stall, 0);
    startin = 1'b0;

    run_op(2'b00, 2'b10, 32'h40, 32'h0, 5'd5, 0, 0);                  // pass-through
    run_op(2'b10, 2'b11, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);       // load, 3-cycle
    run_op(2'b01, 2'b00, 32'h200, 32'h12345678, 5'd0, 1, 32'h55);     // store, 1-cycle
    run_op(2'b10, 2'b11, 32'h103, 32'h0, 5'd3, 1, 32'h0);             // misaligned
    run_op(2'b10, 2'b11, 32'h104, 32'h0, 5'd4, 0, 32'h0);             // timeout
    run_op(2'b10, 2'b11, 32'h108, 32'h0, 5'd4, T, 32'hCAFEF00D);      // ack on last cycle

    // reset in 2nd ACCESS cycle together with ack
    @(negedge clk);
    mem_in = 2'b10; wb_in = 2'b11; alu_in = 32'h300; wreg_in = 5'd9;
    @(negedge clk);
    chk("rst_mid_req1", dif.req, 1);
    @(negedge clk);
    startin = 1'b1; dif.ack = 1'b1; dif.rdata = 32'hBAD0BAD0;
    @(negedge clk);
    startin = 1'b0; dif.ack = 1'b0; mem_in = 2'b00; wb_in = 2'b00;
    check_all_zero("rst_mid");

    run_op(2'b11, 2'b11, 32'h400, 32'h0, 5'd2, 1, 32'h0);             // illegal -> bubble

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, T + 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
